sad_trigger_multi: RTL and testbench

//  Parametrised streaming sum-of-absolute-differences pattern-match trigger on the ADC clock.
//  - Holds an N-sample reference and a per-sample compare-enable mask.
//  - Slides the live ADC stream through an N-sample window and computes a masked SAD in a

---
 rtl/sad_trigger_multi.sv | 228 ++++++++++++++++++++++
 tb/tb_sad_trigger_multi.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_trigger_multi.sv
// Streaming sum-of-absolute-differences pattern-match trigger on the ADC clock.
// A sliding N-sample window is compared against a programmable reference with a
// per-slot compare mask. The masked SAD comes out of a registered adder tree, and
// a match (SAD < threshold) fires a programmable-length trigger pulse. Holdoff,
// one-shot/multi-shot operation, a window-fill guard and min-SAD capture are also
// provided.
`timescale 1ns/1ps

module sad_trigger_multi #(
    parameter int pREF_SAMPLES     = 32,
    parameter int pBITS_PER_SAMPLE = 12,
    parameter int pSUM_WIDTH       = pBITS_PER_SAMPLE + $clog2(pREF_SAMPLES)
) (
    input  logic                            clk_adc,
    input  logic                            reset_n,
    input  logic [pBITS_PER_SAMPLE-1:0]     adc_datain,
    input  logic                            sample_en,
    input  logic                            armed_and_ready,
    input  logic                            ref_wr,
    input  logic [$clog2(pREF_SAMPLES)-1:0] ref_addr,
    input  logic [pBITS_PER_SAMPLE-1:0]     ref_data,
    input  logic                            ref_en,
    input  logic [pSUM_WIDTH-1:0]           threshold,
    input  logic                            multiple_triggers,
    input  logic [15:0]                     holdoff,
    input  logic [3:0]                      trigger_len,
    output logic                            trigger,
    output logic                            triggered,
    output logic [7:0]                      num_triggers,
    output logic [pSUM_WIDTH-1:0]           sad_value,
    output logic [pSUM_WIDTH-1:0]           sad_min
);

    localparam int N         = pREF_SAMPLES;
    localparam int B         = pBITS_PER_SAMPLE;
    localparam int SW        = pSUM_WIDTH;
    localparam int LVLS      = $clog2(N);
    localparam int P         = 1 << LVLS;          // tree width, zero-padded
    localparam int FW        = $clog2(N + 1);
    localparam int pLATENCY  = LVLS + 3;           // last sample edge to trigger rise

    // Unsigned absolute difference of two samples.
    function automatic logic [B-1:0] abs_diff(input logic [B-1:0] a, input logic [B-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Saturating increment for the fire counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    logic armed;
    logic arm_d;
    logic arm_rise;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_nxt;

    logic [B-1:0]  ref_q   [N];
    logic [N-1:0]  mask_q;
    logic [B-1:0]  win_p0  [N];
    logic          vld_p0;
    logic [B-1:0]  diff_p1 [N];
    logic [pLATENCY-3:0] vld_sr;       // [0] = diff stage, then one bit per tree level
    logic [SW-1:0] leaf    [P];
    logic [SW-1:0] child_l [P-1];
    logic [SW-1:0] child_r [P-1];
    logic [SW-1:0] sum_tree[P-1];      // heap layout, [0] is the root
    logic          vld_root;
    logic          match_p;
    logic          fire;
    logic [3:0]    pulse_cnt;
    logic [15:0]   holdoff_cnt;

    assign armed    = armed_and_ready;
    assign arm_rise = armed && !arm_d;
    assign vld_root = vld_sr[pLATENCY-3];

    // Arm edge detector.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) arm_d <= 1'b0;
        else          arm_d <= armed;
    end

    // Fill count: zero while disarmed, counts accepted samples while armed, saturating at N.
    always_comb begin
        fill_nxt = fill_q;
        if (!armed)
            fill_nxt = '0;
        else if (sample_en && (fill_q != FW'(N)))
            fill_nxt = fill_q + 1'b1;
    end

    // Fill counter register.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) fill_q <= '0;
        else          fill_q <= fill_nxt;
    end

    // Reference and compare-mask storage, writable at any time.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) ref_q[i] <= '0;
            mask_q <= '0;
        end else if (ref_wr && (int'(ref_addr) < N)) begin
            ref_q[ref_addr]  <= ref_data;
            mask_q[ref_addr] <= ref_en;
        end
    end

    // Stage p0: sliding window, slot 0 oldest; tag valid once N armed samples are in.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) win_p0[i] <= '0;
            vld_p0 <= 1'b0;
        end else begin
            if (sample_en) begin
                for (int i = 0; i < N - 1; i++) win_p0[i] <= win_p0[i + 1];
                win_p0[N-1] <= adc_datain;
            end
            vld_p0 <= armed && sample_en && (fill_nxt == FW'(N));
        end
    end

    // Stage p1: masked per-slot absolute differences.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) diff_p1[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                diff_p1[i] <= mask_q[i] ? abs_diff(win_p0[i], ref_q[i]) : '0;
        end
    end

    // Tree leaves: real slots zero-extended, padding slots tied to zero.
    for (genvar j = 0; j < P; j++) begin : g_leaf
        if (j < N) begin : g_real
            assign leaf[j] = SW'(diff_p1[j]);
        end else begin : g_pad
            assign leaf[j] = '0;
        end
    end

    // Child selection for each internal tree node.
    for (genvar i = 0; i < P - 1; i++) begin : g_node
        localparam int CL = 2 * i + 1;
        if (CL >= P - 1) begin : g_from_leaf
            assign child_l[i] = leaf[CL - (P - 1)];
            assign child_r[i] = leaf[CL + 1 - (P - 1)];
        end else begin : g_from_node
            assign child_l[i] = sum_tree[CL];
            assign child_r[i] = sum_tree[CL + 1];
        end
    end

    // Stages p2..: one registered adder level per tree depth.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < P - 1; i++) sum_tree[i] <= '0;
        end else begin
            for (int i = 0; i < P - 1; i++) sum_tree[i] <= child_l[i] + child_r[i];
        end
    end

    // Valid tags ride alongside diff and tree stages; disarm flushes them.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n)    vld_sr <= '0;
        else if (!armed) vld_sr <= '0;
        else             vld_sr <= {vld_sr[pLATENCY-4:0], vld_p0};
    end

    // Compare stage: register the match and capture SAD / minimum SAD.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            match_p   <= 1'b0;
            sad_value <= '0;
            sad_min   <= '1;
        end else begin
            match_p <= armed && vld_root && (sum_tree[0] < threshold);
            if (arm_rise) begin
                sad_min <= '1;
            end else if (armed && vld_root) begin
                sad_value <= sum_tree[0];
                if (sum_tree[0] < sad_min) sad_min <= sum_tree[0];
            end
        end
    end

    assign fire = match_p && armed && (holdoff_cnt == 16'd0) && !trigger
                  && (multiple_triggers || (num_triggers == 8'd0));

    // Trigger stage: pulse generation, holdoff timing and fire statistics.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            trigger      <= 1'b0;
            pulse_cnt    <= '0;
            holdoff_cnt  <= '0;
            triggered    <= 1'b0;
            num_triggers <= '0;
        end else begin
            if (!armed) begin
                trigger   <= 1'b0;
                pulse_cnt <= '0;
            end else if (fire) begin
                trigger   <= 1'b1;
                pulse_cnt <= (trigger_len == 4'd0) ? 4'd0 : (trigger_len - 4'd1);
            end else if (trigger) begin
                if (pulse_cnt == 4'd0) trigger <= 1'b0;
                else                   pulse_cnt <= pulse_cnt - 4'd1;
            end

            if (arm_rise)
                holdoff_cnt <= '0;
            else if (fire)
                holdoff_cnt <= holdoff;
            else if (holdoff_cnt != 16'd0)
                holdoff_cnt <= holdoff_cnt - 16'd1;

            if (arm_rise) begin
                triggered    <= 1'b0;
                num_triggers <= '0;
            end else if (fire) begin
                triggered    <= 1'b1;
                num_triggers <= sat_inc8(num_triggers);
            end
        end
    end

endmodule

// File: tb/tb_sad_trigger_multi.sv
// Bench for sad_trigger_multi (N=8, B=12): reset checks, table-driven match
// scenarios, hand-written multi-cycle sequences, and a randomized run compared
// every cycle against a time-stamped behavioural model.
`timescale 1ns/1ps

module tb_sad_trigger_multi;

    localparam int N   = 8;
    localparam int B   = 12;
    localparam int SW  = 15;
    localparam int LAT = 6;

    logic          clk_adc = 1'b0;
    logic          reset_n = 1'b0;
    logic [B-1:0]  adc_datain = '0;
    logic          sample_en = 1'b0;
    logic          armed_and_ready = 1'b0;
    logic          ref_wr = 1'b0;
    logic [2:0]    ref_addr = '0;
    logic [B-1:0]  ref_data = '0;
    logic          ref_en = 1'b0;
    logic [SW-1:0] threshold = '0;
    logic          multiple_triggers = 1'b0;
    logic [15:0]   holdoff = '0;
    logic [3:0]    trigger_len = '0;
    logic          trigger;
    logic          triggered;
    logic [7:0]    num_triggers;
    logic [SW-1:0] sad_value;
    logic [SW-1:0] sad_min;

    sad_trigger_multi #(.pREF_SAMPLES(N), .pBITS_PER_SAMPLE(B)) dut (
        .clk_adc(clk_adc), .reset_n(reset_n), .adc_datain(adc_datain),
        .sample_en(sample_en), .armed_and_ready(armed_and_ready),
        .ref_wr(ref_wr), .ref_addr(ref_addr), .ref_data(ref_data), .ref_en(ref_en),
        .threshold(threshold), .multiple_triggers(multiple_triggers),
        .holdoff(holdoff), .trigger_len(trigger_len), .trigger(trigger),
        .triggered(triggered), .num_triggers(num_triggers),
        .sad_value(sad_value), .sad_min(sad_min));

    always #5 clk_adc = ~clk_adc;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Windows are time-stamped at their last-sample edge; capture happens at
    // stamp+LAT-1 and a fire at stamp+LAT. Pulse and holdoff are tracked as
    // edge-number intervals.
    typedef struct { int t; int sad; bit match; } pend_t;
    pend_t       q[$];
    logic [B-1:0] m_win[N];
    logic [B-1:0] m_ref[N];
    bit          m_mask[N];
    int cyc = 0;
    int m_fill, m_num, m_sadv, m_sadmin, m_sad, m_d;
    bit m_sticky, m_prev_arm, m_fire;
    int last_fire, trig_until, hold_until;

    always @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin m_win[i] = '0; m_ref[i] = '0; m_mask[i] = 1'b0; end
            q.delete();
            m_fill = 0; m_num = 0; m_sadv = 0; m_sadmin = (1 << SW) - 1;
            m_sticky = 1'b0; m_prev_arm = 1'b0;
            last_fire = -1000; trig_until = -1000; hold_until = -1000;
        end else begin
            cyc++;
            if (ref_wr) begin m_ref[ref_addr] = ref_data; m_mask[ref_addr] = ref_en; end
            if (sample_en) begin
                for (int i = 0; i < N - 1; i++) m_win[i] = m_win[i + 1];
                m_win[N-1] = adc_datain;
            end
            if (!armed_and_ready) begin
                q.delete();
                m_fill = 0;
                if (trig_until > cyc - 1) trig_until = cyc - 1;
            end else begin
                if (!m_prev_arm) begin
                    m_num = 0; m_sticky = 1'b0; m_sadmin = (1 << SW) - 1;
                    if (hold_until > cyc) hold_until = cyc;
                end
                m_fire = 1'b0;
                foreach (q[i]) begin
                    if (q[i].t + LAT - 1 == cyc) begin
                        m_sadv = q[i].sad;
                        if (q[i].sad < m_sadmin) m_sadmin = q[i].sad;
                        q[i].match = (q[i].sad < int'(threshold));
                    end else if (q[i].t + LAT == cyc && q[i].match) begin
                        if (cyc > hold_until && !(cyc - 1 >= last_fire && cyc - 1 <= trig_until)
                            && (multiple_triggers || m_num == 0))
                            m_fire = 1'b1;
                    end
                end
                if (m_fire) begin
                    if (m_num < 255) m_num++;
                    m_sticky   = 1'b1;
                    last_fire  = cyc;
                    trig_until = cyc + ((trigger_len == 4'd0) ? 1 : int'(trigger_len)) - 1;
                    hold_until = cyc + int'(holdoff);
                end
                while (q.size() > 0 && q[0].t + LAT <= cyc) void'(q.pop_front());
                if (sample_en && m_fill < N) m_fill++;
                if (sample_en && m_fill == N) begin
                    m_sad = 0;
                    for (int i = 0; i < N; i++) begin
                        m_d = int'(m_win[i]) - int'(m_ref[i]);
                        if (m_mask[i]) m_sad += (m_d < 0) ? -m_d : m_d;
                    end
                    q.push_back('{cyc, m_sad, 1'b0});
                end
            end
            m_prev_arm = armed_and_ready;
        end
    end

    bit chk_en = 1'b0;
    logic exp_trig;

    // Per-cycle comparison of all outputs against the model, on the falling edge.
    always @(negedge clk_adc) begin
        if (chk_en) begin
            exp_trig = (cyc >= last_fire) && (cyc <= trig_until);
            check("model_outputs",
                  {7'd0, trigger, triggered, num_triggers, sad_value},
                  {7'd0, exp_trig, m_sticky, 8'(m_num), 15'(m_sadv)});
            check("model_sad_min", {17'd0, sad_min}, {17'd0, 15'(m_sadmin)});
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [B-1:0] pat[N];

    task automatic tick();
        @(posedge clk_adc);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic load_ref(input logic [7:0] mask);
        for (int i = 0; i < N; i++) begin
            ref_wr = 1'b1; ref_addr = 3'(i); ref_data = pat[i]; ref_en = mask[i];
            tick();
        end
        ref_wr = 1'b0;
    endtask

    task automatic send(input logic [B-1:0] s);
        adc_datain = s; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic send_pat();
        for (int i = 0; i < N; i++) send(pat[i]);
    endtask

    task automatic rearm();
        armed_and_ready = 1'b0; tick();
        armed_and_ready = 1'b1; tick();
    endtask

    typedef struct {
        logic [SW-1:0] thr;
        logic [7:0]    mask;
        bit            dev;
        int            exp_num;
        int            exp_min;
    } vec_t;

    vec_t vecs[5];
    logic [B-1:0] s;
    int cnt;
    int k;

    initial begin
        vecs[0] = '{15'd1,   8'hFF,        1'b0, 1, 0};
        vecs[1] = '{15'd100, 8'hFF,        1'b1, 0, 100};
        vecs[2] = '{15'd101, 8'hFF,        1'b1, 1, 100};
        vecs[3] = '{15'd1,   8'b1101_1011, 1'b0, 1, 0};
        vecs[4] = '{15'd0,   8'hFF,        1'b0, 0, 0};
        for (int i = 0; i < N; i++) pat[i] = 12'(200 + 450 * i);

        // Reset state
        idle(3);
        check("rst_trigger",   {31'd0, trigger}, 32'd0);
        check("rst_triggered", {31'd0, triggered}, 32'd0);
        check("rst_num",       {24'd0, num_triggers}, 32'd0);
        check("rst_sad_value", {17'd0, sad_value}, 32'd0);
        check("rst_sad_min",   {17'd0, sad_min}, 32'h7FFF);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();

        // Exact pattern: latency and single-cycle pulse
        threshold = 15'd1; trigger_len = 4'd1; holdoff = 16'd0; multiple_triggers = 1'b0;
        load_ref(8'hFF);
        rearm();
        send_pat();
        for (int j = 1; j <= LAT - 1; j++) begin
            tick();
            check("t1_before_latency", {31'd0, trigger}, 32'd0);
        end
        tick(); check("t1_rise", {31'd0, trigger}, 32'd1);
        tick(); check("t1_fall", {31'd0, trigger}, 32'd0);
        check("t1_num",       {24'd0, num_triggers}, 32'd1);
        check("t1_sad_value", {17'd0, sad_value}, 32'd0);
        check("t1_triggered", {31'd0, triggered}, 32'd1);

        // Table-driven single-window scenarios
        for (int v = 0; v < 5; v++) begin
            threshold = vecs[v].thr;
            load_ref(vecs[v].mask);
            rearm();
            for (int i = 0; i < N; i++) begin
                s = pat[i];
                if (vecs[v].dev && i == 3) s = s + 12'd60;
                if (vecs[v].dev && i == 6) s = s - 12'd40;
                if (!vecs[v].mask[i]) s = 12'($urandom_range(0, 4095));
                send(s);
            end
            idle(10);
            check($sformatf("vec%0d_num", v),     {24'd0, num_triggers}, 32'(vecs[v].exp_num));
            check($sformatf("vec%0d_sad_min", v), {17'd0, sad_min},      32'(vecs[v].exp_min));
            check($sformatf("vec%0d_sad_val", v), {17'd0, sad_value},    32'(vecs[v].exp_min));
        end

        // One trigger per arm
        threshold = 15'd1; load_ref(8'hFF);
        multiple_triggers = 1'b0; rearm();
        send_pat(); send_pat(); idle(10);
        check("t4_single_shot", {24'd0, num_triggers}, 32'd1);

        // Holdoff 20: repeat 8 cycles later is ignored
        multiple_triggers = 1'b1; holdoff = 16'd20; rearm();
        send_pat(); send_pat(); idle(10);
        check("t4_holdoff_block", {24'd0, num_triggers}, 32'd1);

        // Holdoff 20: repeat 40 cycles later fires again
        rearm();
        send_pat(); idle(32); send_pat(); idle(10);
        check("t4_holdoff_pass", {24'd0, num_triggers}, 32'd2);

        // Three-cycle pulse
        holdoff = 16'd0; trigger_len = 4'd3; rearm();
        send_pat();
        cnt = 0;
        for (int j = 0; j < 14; j++) begin
            tick();
            if (trigger) cnt++;
        end
        check("t4_pulse_len3", 32'(cnt), 32'd3);
        trigger_len = 4'd1; multiple_triggers = 1'b0;

        // Fill guard: half the pattern before arm
        armed_and_ready = 1'b0; tick();
        for (int i = 0; i < 4; i++) send(pat[i]);
        armed_and_ready = 1'b1;
        for (int i = 4; i < N; i++) send(pat[i]);
        idle(10);
        check("t5_prearm_no_fire", {24'd0, num_triggers}, 32'd0);
        send_pat(); idle(10);
        check("t5_postarm_fire", {24'd0, num_triggers}, 32'd1);

        // Decimated stream: sample_en alternating
        rearm();
        for (int i = 0; i < N; i++) begin send(pat[i]); tick(); end
        idle(10);
        check("t6_alternating", {24'd0, num_triggers}, 32'd1);

        // Async reset in the middle of a long pulse
        trigger_len = 4'd8; rearm();
        send_pat();
        for (int j = 0; j < 20 && !trigger; j++) tick();
        check("t6_pulse_seen", {31'd0, trigger}, 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        check("t6_rst_trigger",   {31'd0, trigger}, 32'd0);
        check("t6_rst_num",       {24'd0, num_triggers}, 32'd0);
        check("t6_rst_triggered", {31'd0, triggered}, 32'd0);
        check("t6_rst_sad_min",   {17'd0, sad_min}, 32'h7FFF);
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized run against the model
        threshold = 15'd300; trigger_len = 4'd2; holdoff = 16'd5; multiple_triggers = 1'b1;
        load_ref(8'($urandom_range(0, 255)) | 8'h81);
        rearm();
        k = 0;
        for (int c = 0; c < 3000; c++) begin
            if (armed_and_ready && $urandom_range(0, 199) == 0) armed_and_ready = 1'b0;
            else if (!armed_and_ready && $urandom_range(0, 3) == 0) armed_and_ready = 1'b1;
            if ($urandom_range(0, 99) == 0) multiple_triggers = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) holdoff = 16'($urandom_range(0, 30));
            if ($urandom_range(0, 99) == 0) trigger_len = 4'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) threshold = 15'($urandom_range(0, 600));
            ref_wr = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                ref_wr   = 1'b1;
                ref_addr = 3'($urandom_range(0, 7));
                ref_data = 12'($urandom_range(0, 4095));
                ref_en   = 1'($urandom_range(0, 1));
            end
            sample_en = ($urandom_range(0, 3) != 0);
            adc_datain = 12'(int'(pat[k]) + int'($urandom_range(0, 20)) - 10);
            if (sample_en) k = (k + 1) % N;
            tick();
        end
        ref_wr = 1'b0; sample_en = 1'b0;
        idle(10);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
